// File: rtl/sd_pkg.sv
// Shared definitions for the SD multi-sector reader: state encoding, sector size, helpers.
// No logic, no latency, no flow control.
package sd_pkg;

    localparam int SD_SEC_WORDS = 256;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ROOM,
        START,
        WAIT_BUSY,
        READ,
        CHECK,
        DONE
    } sd_state_t;

    function automatic logic [15:0] byte_swap(input logic [15:0] w);
        return {w[7:0], w[15:8]};
    endfunction

endpackage

// File: rtl/sd_sec_reader_if.sv
// Sector-read handshake between the multi-sector reader (master) and the SD read stage (slave).
// Pure wiring; the slave holds rd_busy high for the whole sector it is returning.
interface sd_sec_reader_if;
    logic        rd_start_en;
    logic [31:0] rd_sec_addr;
    logic        rd_busy;
    logic        rd_val_en;
    logic [15:0] rd_val_data;

    modport master (
        output rd_start_en, rd_sec_addr,
        input  rd_busy, rd_val_en, rd_val_data
    );

    modport slave (
        input  rd_start_en, rd_sec_addr,
        output rd_busy, rd_val_en, rd_val_data
    );
endinterface

// File: rtl/sd_rd_wdog.sv
// Watchdog counting enabled cycles; expired flags the last of TO_CYC enabled cycles.
// Latency: combinational expired from the registered count; no backpressure.
module sd_rd_wdog #(
    parameter int TO_CYC = 65535
) (
    input  logic clk_ref,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(TO_CYC + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && cnt != CW'(TO_CYC)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = enable && (cnt == CW'(TO_CYC - 1));
endmodule

// File: rtl/sd_sec_reader.sv
// Multi-sector SD read sequencer: issues one sector read at a time and forwards words downstream.
// Latency: words forwarded 1 cycle after rd_val_en; waits on room_ok before each sector.
// Build option SD_RD_BYTE_SWAP_EN swaps the two bytes of every forwarded word.
module sd_sec_reader
    import sd_pkg::*;
#(
    parameter int SEC_WORDS = SD_SEC_WORDS,
    parameter int TO_CYC    = 65535
) (
    input  logic                   clk_ref,
    input  logic                   rst_n,
    input  logic                   sd_init_done,
    input  logic                   start,
    input  logic [31:0]            base_addr,
    input  logic [15:0]            sec_num,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [15:0]            sec_cnt,
    sd_sec_reader_if.master        rd,
    input  logic                   room_ok,
    output logic                   out_en,
    output logic [15:0]            out_data
);
    localparam int               WC_W    = $clog2(SEC_WORDS + 2);
    localparam logic [WC_W-1:0]  WC_MAX  = WC_W'(SEC_WORDS + 1);
    localparam logic [WC_W-1:0]  WC_FULL = WC_W'(SEC_WORDS);

    sd_state_t       state;
    logic [31:0]     base_l;
    logic [15:0]     num_l;
    logic [15:0]     idx;
    logic [WC_W-1:0] wcnt;
    logic [15:0]     rx_word;
    logic            wd_expired;

`ifdef SD_RD_BYTE_SWAP_EN
    assign rx_word = byte_swap(rd.rd_val_data);
`else
    assign rx_word = rd.rd_val_data;
`endif

    sd_rd_wdog #(.TO_CYC(TO_CYC)) u_wdog (
        .clk_ref (clk_ref),
        .rst_n   (rst_n),
        .clear   (state != WAIT_BUSY),
        .enable  (state == WAIT_BUSY),
        .expired (wd_expired)
    );

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            sec_cnt        <= '0;
            rd.rd_start_en <= 1'b0;
            rd.rd_sec_addr <= '0;
            out_en         <= 1'b0;
            out_data       <= '0;
            base_l         <= '0;
            num_l          <= '0;
            idx            <= '0;
            wcnt           <= '0;
        end else begin
            done           <= 1'b0;
            rd.rd_start_en <= 1'b0;
            out_en         <= 1'b0;
            // Losing the card mid-transfer is terminal for this transfer only.
            if (state != IDLE && state != DONE && !sd_init_done) begin
                err   <= 1'b1;
                state <= DONE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && sd_init_done) begin
                            base_l  <= base_addr;
                            num_l   <= sec_num;
                            err     <= 1'b0;
                            sec_cnt <= '0;
                            idx     <= '0;
                            wcnt    <= '0;
                            busy    <= 1'b1;
                            state   <= (sec_num == 16'd0) ? DONE : WAIT_ROOM;
                        end
                    end
                    WAIT_ROOM: begin
                        if (room_ok) begin
                            rd.rd_start_en <= 1'b1;
                            rd.rd_sec_addr <= base_l + {16'd0, idx};
                            state          <= START;
                        end
                    end
                    START: state <= WAIT_BUSY;
                    WAIT_BUSY: begin
                        if (rd.rd_busy) begin
                            state <= READ;
                        end else if (wd_expired) begin
                            err   <= 1'b1;
                            state <= DONE;
                        end
                    end
                    READ: begin
                        if (rd.rd_val_en) begin
                            out_en   <= 1'b1;
                            out_data <= rx_word;
                            if (wcnt != WC_MAX) wcnt <= wcnt + 1'b1;
                        end
                        if (!rd.rd_busy) state <= CHECK;
                    end
                    CHECK: begin
                        // A short or long sector is flagged but the remaining sectors are still read.
                        if (wcnt != WC_FULL) err <= 1'b1;
                        wcnt    <= '0;
                        sec_cnt <= sec_cnt + 16'd1;
                        idx     <= idx + 16'd1;
                        state   <= (idx + 16'd1 == num_l) ? DONE : WAIT_ROOM;
                    end
                    DONE: begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sd_sec_reader.sv
// Directed bench for sd_sec_reader: table of multi-sector transfers plus hand-written corner cases.
module tb_sd_sec_reader;

    typedef struct {
        logic [31:0] base;
        logic [15:0] num;
        bit          hold;
        int          short_sec;
        int          exp_words;
        logic        exp_err;
        logic [15:0] exp_cnt;
    } vec_t;

    logic        clk_ref = 1'b0;
    logic        rst_n = 1'b1;
    logic        sd_init_done = 1'b0;
    logic        start = 1'b0;
    logic        room_ok = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] sec_num = '0;
    logic        busy, done, err, out_en;
    logic [15:0] sec_cnt, out_data;

    sd_sec_reader_if rd();

    sd_sec_reader #(.SEC_WORDS(256), .TO_CYC(100)) dut (
        .clk_ref      (clk_ref),
        .rst_n        (rst_n),
        .sd_init_done (sd_init_done),
        .start        (start),
        .base_addr    (base_addr),
        .sec_num      (sec_num),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .sec_cnt      (sec_cnt),
        .rd           (rd),
        .room_ok      (room_ok),
        .out_en       (out_en),
        .out_data     (out_data)
    );

    always #5 clk_ref = ~clk_ref;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int starts = 0, dones = 0, words = 0, data_bad = 0;
    int start_cyc = 0, done_cyc = 0;
    logic [15:0] exp_q[$];
    logic [31:0] addr_q[$];
    bit model_nobusy = 0;
    bit model_abort = 0;
    int short_sec = -1;
    int sec_seen = 0;
    vec_t vecs[5];

    always @(posedge clk_ref) cyc = cyc + 1;

    // Observers sample on the falling edge, half a cycle clear of DUT updates.
    always @(negedge clk_ref) begin
        logic [15:0] e;
        if (rd.rd_start_en === 1'b1) begin
            starts++;
            start_cyc = cyc;
        end
        if (done === 1'b1) begin
            dones++;
            done_cyc = cyc;
        end
        if (out_en === 1'b1) begin
            words++;
            if (exp_q.size() == 0) begin
                data_bad++;
            end else begin
                e = exp_q.pop_front();
                if (out_data !== e) data_bad++;
            end
        end
    end

    task automatic serve(input int s);
        int n;
        logic [15:0] w;
        n = (s == short_sec) ? 255 : 256;
        @(negedge clk_ref);
        rd.rd_busy = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_ref);
            if (model_abort) break;
            w = 16'(i * 7 + s * 16'h1001 + 16'h0300);
            rd.rd_val_en   = 1'b1;
            rd.rd_val_data = w;
            exp_q.push_back(w);
        end
        @(negedge clk_ref);
        rd.rd_val_en = 1'b0;
        rd.rd_busy   = 1'b0;
    endtask

    // SD read stage model: busy one cycle after the request, then one word per cycle.
    initial begin
        rd.rd_busy     = 1'b0;
        rd.rd_val_en   = 1'b0;
        rd.rd_val_data = '0;
        forever begin
            @(negedge clk_ref);
            if (rd.rd_start_en === 1'b1 && !model_abort) begin
                addr_q.push_back(rd.rd_sec_addr);
                if (!model_nobusy) serve(sec_seen);
                sec_seen++;
            end
        end
    end

    task automatic tick;
        @(negedge clk_ref);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic clear_obs;
        starts = 0; dones = 0; words = 0; data_bad = 0; sec_seen = 0;
        addr_q.delete();
        exp_q.delete();
    endtask

    task automatic run_vec(input int k, input vec_t v);
        int st;
        bit held, seen_short;
        held = 0;
        seen_short = 0;
        short_sec = v.short_sec;
        clear_obs();
        room_ok = 1'b1;
        base_addr = v.base;
        sec_num = v.num;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 6000 && dones == 0; c++) begin
            tick();
            if (v.hold && !held && sec_cnt == 16'd1) begin
                held = 1;
                room_ok = 1'b0;
                st = starts;
                repeat (500) tick();
                chk($sformatf("v%0d_hold_no_start", k), starts, st);
                chk($sformatf("v%0d_hold_busy", k), busy, 1);
                room_ok = 1'b1;
            end
            if (v.short_sec >= 0 && !seen_short && sec_cnt == 16'(v.short_sec + 1)) begin
                seen_short = 1;
                chk($sformatf("v%0d_err_after_short", k), err, 1);
            end
        end
        chk($sformatf("v%0d_done_seen", k), dones, 1);
        chk($sformatf("v%0d_busy_at_done", k), busy, 0);
        repeat (3) tick();
        chk($sformatf("v%0d_done_once", k), dones, 1);
        chk($sformatf("v%0d_err", k), err, v.exp_err);
        chk($sformatf("v%0d_sec_cnt", k), sec_cnt, v.exp_cnt);
        chk($sformatf("v%0d_words", k), words, v.exp_words);
        chk($sformatf("v%0d_data_bad", k), data_bad, 0);
        chk($sformatf("v%0d_starts", k), starts, v.num);
        for (int i = 0; i < int'(v.num); i++)
            chk($sformatf("v%0d_addr%0d", k, i),
                (addr_q.size() > i) ? addr_q[i] : 32'hDEAD_BEEF, v.base + 32'(i));
    endtask

    initial begin
        int st, d0, lat;
        bit hit;
        vecs[0] = '{base: 32'h0000_0100, num: 16'd3, hold: 0, short_sec: -1, exp_words: 768, exp_err: 1'b0, exp_cnt: 16'd3};
        vecs[1] = '{base: 32'hFFFF_FFFF, num: 16'd2, hold: 0, short_sec: -1, exp_words: 512, exp_err: 1'b0, exp_cnt: 16'd2};
        vecs[2] = '{base: 32'h0000_0040, num: 16'd2, hold: 1, short_sec: -1, exp_words: 512, exp_err: 1'b0, exp_cnt: 16'd2};
        vecs[3] = '{base: 32'h0000_0200, num: 16'd3, hold: 0, short_sec: 1,  exp_words: 767, exp_err: 1'b1, exp_cnt: 16'd3};
        vecs[4] = '{base: 32'h0000_0010, num: 16'd1, hold: 0, short_sec: -1, exp_words: 256, exp_err: 1'b0, exp_cnt: 16'd1};

        #2 rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_sec_cnt", sec_cnt, 0);
        chk("rst_start_en", rd.rd_start_en, 0);
        chk("rst_sec_addr", rd.rd_sec_addr, 0);
        chk("rst_out_en", out_en, 0);
        chk("rst_out_data", out_data, 0);
        rst_n = 1'b1;
        sd_init_done = 1'b1;
        room_ok = 1'b1;
        tick();

        for (int k = 0; k < 5; k++) run_vec(k, vecs[k]);

        // Empty transfer: done two cycles after start, no sector request.
        clear_obs();
        sec_num = 16'd0;
        base_addr = 32'h55;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("zero_done_early", done, 0);
        chk("zero_busy", busy, 1);
        tick();
        chk("zero_done", done, 1);
        chk("zero_busy_idle", busy, 0);
        chk("zero_no_start", starts, 0);

        // Start while the card is not initialised is ignored.
        sd_init_done = 1'b0;
        sec_num = 16'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk("noinit_busy", busy, 0);
        chk("noinit_no_start", starts, 0);
        sd_init_done = 1'b1;
        tick();

        // Read stage never answers: watchdog ends the transfer.
        clear_obs();
        model_nobusy = 1;
        base_addr = 32'h5;
        sec_num = 16'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 400 && dones == 0; c++) tick();
        lat = done_cyc - start_cyc;
        chk("to_done_seen", dones, 1);
        chk("to_lat_in_range", (lat >= 100 && lat <= 102), 1);
        chk("to_err", err, 1);
        chk("to_sec_cnt", sec_cnt, 0);
        model_nobusy = 0;
        repeat (3) tick();

        // Reset during the second sector's data phase.
        clear_obs();
        base_addr = 32'h300;
        sec_num = 16'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        hit = 0;
        for (int c = 0; c < 2000 && !hit; c++) begin
            tick();
            if (sec_cnt == 16'd1 && out_en === 1'b1) hit = 1;
        end
        chk("mid_reached_read", hit, 1);
        model_abort = 1;
        d0 = dones;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_err", err, 0);
        chk("mid_sec_cnt", sec_cnt, 0);
        chk("mid_sec_addr", rd.rd_sec_addr, 0);
        chk("mid_out_en", out_en, 0);
        chk("mid_out_data", out_data, 0);
        chk("mid_start_en", rd.rd_start_en, 0);
        repeat (5) tick();
        chk("mid_no_done", dones, d0);
        rst_n = 1'b1;
        model_abort = 0;
        repeat (3) tick();
        chk("mid_idle_after", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: bench did not finish, compared %0d", n_cmp);
        $fatal(1, "bench timeout");
    end

endmodule
